// File: rtl/uart_pkg.sv
// Shared UART types, oversampling constants and stop-length helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int LAST_TICK  = 15;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1P5 = 2'd1,
    STOP_2   = 2'd2
  } stop_bits_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // Sample ticks spanned by the stop period, measured from the last data/parity sample.
  function automatic int stop_ticks(stop_bits_e sb);
    case (sb)
      STOP_1P5: return 24;
      STOP_2:   return 32;
      default:  return 16;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-to-consumer word handshake with error flags and overrun control.
interface uart_rx_cfg_if #(parameter int DataBitsMax = 9);
  logic [DataBitsMax-1:0] dout_o;
  logic                   rx_valid_o;
  logic                   parity_err_o;
  logic                   frame_err_o;
  logic                   break_o;
  logic                   overrun_o;
  logic                   rx_ready_i;
  logic                   overrun_clr_i;

  modport master (
    output dout_o, rx_valid_o, parity_err_o, frame_err_o, break_o, overrun_o,
    input  rx_ready_i, overrun_clr_i
  );

  modport slave (
    input  dout_o, rx_valid_o, parity_err_o, frame_err_o, break_o, overrun_o,
    output rx_ready_i, overrun_clr_i
  );
endinterface

// File: rtl/sync_2ff.sv
// Multi-flop bit synchronizer; resets to 1 so an idle-high line looks idle.
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ff <= '1;
    else       ff <= {ff[STAGES-2:0], d_i};
  end

  assign q_o = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable 16x oversampling UART receiver with valid/ready output.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DataBitsMax = 9,
  parameter int Oversample  = 16,
  parameter int SyncStages  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 sample_tick_i,
  input  logic [3:0]           data_bits_i,
  input  logic [1:0]           parity_mode_i,
  input  logic [1:0]           stop_bits_i,
  uart_rx_cfg_if.master        rx_if
);

  // Counter must reach the longest stop period (2 bit times).
  localparam int CNT_W = $clog2(2 * Oversample);

  logic rx_s;

  sync_2ff #(.STAGES(SyncStages)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DataBitsMax-1:0] buf_q, buf_d;
  logic                   pbit_q, pbit_d;
  logic [3:0]             nbits_q, nbits_d;
  parity_mode_e           par_q, par_d;
  stop_bits_e             stop_q, stop_d;
  logic                   done, ferr_c, perr_c, brk_c;

  logic [3:0]   nbits_in;
  parity_mode_e par_in;
  stop_bits_e   stop_in;

  // Decode raw configuration, mapping illegal encodings to their defaults.
  always_comb begin
    nbits_in = (data_bits_i >= 4'd5 && data_bits_i <= 4'(DataBitsMax)) ? data_bits_i : 4'd8;
    par_in   = (parity_mode_i == 2'd3) ? PAR_NONE : parity_mode_e'(parity_mode_i);
    stop_in  = (stop_bits_i == 2'd3) ? STOP_1 : stop_bits_e'(stop_bits_i);
  end

  // FSM state and frame datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      buf_q   <= '0;
      pbit_q  <= 1'b0;
      nbits_q <= 4'd8;
      par_q   <= PAR_NONE;
      stop_q  <= STOP_1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      buf_q   <= buf_d;
      pbit_q  <= pbit_d;
      nbits_q <= nbits_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
    end
  end

  // Next-state logic: all sampling happens on tick at fixed counter values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    buf_d   = buf_q;
    pbit_d  = pbit_q;
    nbits_d = nbits_q;
    par_d   = par_q;
    stop_d  = stop_q;
    done    = 1'b0;
    ferr_c  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
          buf_d   = '0;
          pbit_d  = 1'b0;
          nbits_d = nbits_in;
          par_d   = par_in;
          stop_d  = stop_in;
        end
      end
      RX_START: begin
        if (sample_tick_i) begin
          if (cnt_q == CNT_W'(MID_TICK)) begin
            cnt_d = '0;
            bit_d = '0;
            // A start bit that is high again by mid-bit was a glitch.
            state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (sample_tick_i) begin
          if (cnt_q == CNT_W'(LAST_TICK)) begin
            cnt_d = '0;
            for (int i = 0; i < DataBitsMax; i++)
              if (bit_q == 4'(i)) buf_d[i] = rx_s;
            if (bit_q == nbits_q - 4'd1)
              state_d = (par_q != PAR_NONE) ? RX_PARITY : RX_STOP;
            else
              bit_d = bit_q + 4'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (sample_tick_i) begin
          if (cnt_q == CNT_W'(LAST_TICK)) begin
            cnt_d   = '0;
            pbit_d  = rx_s;
            state_d = RX_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (sample_tick_i) begin
          if (cnt_q == CNT_W'(LAST_TICK) && !rx_s) begin
            // Bad stop bit: finish now and wait for the line to release.
            done    = 1'b1;
            ferr_c  = 1'b1;
            state_d = RX_WAIT_IDLE;
          end else if (cnt_q == CNT_W'(stop_ticks(stop_q) - 1)) begin
            done    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Error flags for the completing frame, from the captured data and parity bit.
  always_comb begin
    perr_c = (par_q != PAR_NONE) && ((^buf_q ^ pbit_q) == (par_q == PAR_EVEN));
    brk_c  = ferr_c && (buf_q == '0) && ((par_q == PAR_NONE) || !pbit_q);
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_if.dout_o       <= '0;
      rx_if.rx_valid_o   <= 1'b0;
      rx_if.parity_err_o <= 1'b0;
      rx_if.frame_err_o  <= 1'b0;
      rx_if.break_o      <= 1'b0;
      rx_if.overrun_o    <= 1'b0;
    end else begin
      if (done && (!rx_if.rx_valid_o || rx_if.rx_ready_i)) begin
        rx_if.dout_o       <= buf_q;
        rx_if.rx_valid_o   <= 1'b1;
        rx_if.parity_err_o <= perr_c;
        rx_if.frame_err_o  <= ferr_c;
        rx_if.break_o      <= brk_c;
      end else if (rx_if.rx_valid_o && rx_if.rx_ready_i) begin
        rx_if.rx_valid_o <= 1'b0;
      end
      // A dropped frame outranks a simultaneous clear.
      if (done && rx_if.rx_valid_o && !rx_if.rx_ready_i)
        rx_if.overrun_o <= 1'b1;
      else if (rx_if.overrun_clr_i)
        rx_if.overrun_o <= 1'b0;
    end
  end

endmodule
